// File: rtl/fir_sym_dual.sv
// Dual-channel (IR/RED) symmetric FIR low-pass sharing one pre-add/multiply/accumulate datapath.
// Each accepted sample costs NTAPS/2 MAC cycles plus one result cycle.
module fir_sym_dual #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned NTAPS  = 22,
  parameter int unsigned OUT_W  = 20
) (
  input  logic                       CLK_Filter,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_ch,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS/2)-1:0] coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  output logic                       out_valid,
  output logic                       out_ch,
  output logic [OUT_W-1:0]           out_data
);

  localparam int unsigned H      = NTAPS / 2;
  localparam int unsigned AW     = $clog2(H);
  localparam int unsigned TW     = $clog2(NTAPS);
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W + 1;
  localparam int unsigned ACC_W  = PROD_W + AW;
  localparam int unsigned EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [AW-1:0] IDX_LAST = AW'(H - 1);
  localparam logic [AW:0]   H_LIM    = (AW + 1)'(H);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q [2][NTAPS];
  logic [COEF_W-1:0] coef_q [H];
  logic [AW-1:0]     idx_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ch_q;
  logic              out_ch_q;
  logic [OUT_W-1:0]  out_data_q;

  logic              accept;
  logic              coef_wr;
  logic              live;
  logic [TW-1:0]     lo_idx, hi_idx;
  logic [PRE_W-1:0]  pre_sum;
  logic [PROD_W-1:0] prod;
  logic [EXT_W-1:0]  acc_ext;
  logic [OUT_W-1:0]  sat_val;

  function automatic logic [COEF_W-1:0] coef_rst(int unsigned i);
    case (i)
      0:       return COEF_W'(2);
      1:       return COEF_W'(10);
      2:       return COEF_W'(16);
      3:       return COEF_W'(28);
      4:       return COEF_W'(43);
      5:       return COEF_W'(60);
      6:       return COEF_W'(78);
      7:       return COEF_W'(95);
      8:       return COEF_W'(111);
      9:       return COEF_W'(122);
      10:      return COEF_W'(128);
      default: return '0;
    endcase
  endfunction

  // Tap idx pairs with its mirror NTAPS-1-idx of the latched channel's line.
  always_comb begin
    lo_idx  = TW'(idx_q);
    hi_idx  = TW'(NTAPS - 1) - lo_idx;
    pre_sum = PRE_W'(x_q[ch_q][lo_idx]) + PRE_W'(x_q[ch_q][hi_idx]);
    prod    = PROD_W'(pre_sum) * PROD_W'(coef_q[idx_q]);
    acc_ext = EXT_W'(acc_q);
    sat_val = (acc_ext > EXT_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : acc_ext[OUT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    coef_wr  = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        coef_wr  = coef_we && !flush && ({1'b0, coef_addr} < H_LIM);
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = StMac;
        end
      end
      StMac: begin
        if (idx_q == IDX_LAST) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // The result is visible during DONE; a flush or reset in that cycle withdraws it.
  assign live      = (state_q == StDone) && !flush && rst_n;
  assign out_valid = live;
  assign out_ch    = live ? ch_q : out_ch_q;
  assign out_data  = live ? sat_val : out_data_q;

  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      acc_q      <= '0;
      ch_q       <= 1'b0;
      out_ch_q   <= 1'b0;
      out_data_q <= '0;
      for (int h = 0; h < H; h++) coef_q[h] <= coef_rst(h);
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < NTAPS; k++) x_q[c][k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (coef_wr) coef_q[coef_addr] <= coef_data;
      if (flush) begin
        acc_q <= '0;
        for (int c = 0; c < 2; c++) begin
          for (int k = 0; k < NTAPS; k++) x_q[c][k] <= '0;
        end
      end else if (accept) begin
        x_q[in_ch][0] <= in_data;
        for (int k = 1; k < NTAPS; k++) x_q[in_ch][k] <= x_q[in_ch][k-1];
        ch_q  <= in_ch;
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == StMac) begin
        acc_q <= acc_q + ACC_W'(prod);
        idx_q <= idx_q + AW'(1);
      end else if (state_q == StDone) begin
        out_data_q <= sat_val;
        out_ch_q   <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_fir_sym_dual.sv
// Bench for fir_sym_dual: directed literal checks plus random traffic against a full-length
// symmetric FIR model, with a 20-bit and an 18-bit (saturating) instance side by side.
module tb_fir_sym_dual;

  localparam int NT = 22;
  localparam int H  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, in_valid = 1'b0, in_ch = 1'b0, flush = 1'b0, coef_we = 1'b0;
  logic [7:0] in_data = '0, coef_data = '0;
  logic [3:0] coef_addr = '0;
  logic       rdy, ov, och, rdy_s, ov_s, och_s;
  logic [19:0] od;
  logic [17:0] od_s;

  fir_sym_dual #(.DATA_W(8), .COEF_W(8), .NTAPS(22), .OUT_W(20)) dut (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_ready(rdy), .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(ov), .out_ch(och), .out_data(od)
  );

  fir_sym_dual #(.DATA_W(8), .COEF_W(8), .NTAPS(22), .OUT_W(18)) dut_s (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_ready(rdy_s), .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(ov_s), .out_ch(och_s), .out_data(od_s)
  );

  int     rc [H] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
  int     mc [H];
  int     mx [2][NT];
  int     m_cnt = 0, m_ch = 0, last_ch = 0;
  longint m_res = 0, last20 = 0, last18 = 0;
  bit     chk_en = 1'b0;
  int     n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Full-length convolution with the symmetric impulse response expanded from the H unique taps.
  function automatic longint fir(input int c);
    longint s;
    s = 0;
    for (int k = 0; k < NT; k++) s += longint'(mc[(k < H) ? k : NT - 1 - k]) * mx[c][k];
    return s;
  endfunction

  // Model: a sample accepted while idle is busy for H+1 cycles; the last of those shows the result.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < H; i++) mc[i] = rc[i];
      for (int c = 0; c < 2; c++) for (int k = 0; k < NT; k++) mx[c][k] = 0;
      m_cnt = 0; m_ch = 0; m_res = 0; last20 = 0; last18 = 0; last_ch = 0;
    end else if (flush) begin
      for (int c = 0; c < 2; c++) for (int k = 0; k < NT; k++) mx[c][k] = 0;
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (coef_we && coef_addr < H) mc[coef_addr] = coef_data;
      if (in_valid) begin
        for (int k = NT - 1; k > 0; k--) mx[in_ch][k] = mx[in_ch][k-1];
        mx[in_ch][0] = in_data;
        m_ch  = in_ch;
        m_res = fir(in_ch);
        m_cnt = H + 1;
      end
    end else begin
      if (m_cnt == 1) begin
        last20 = sat(m_res, 20); last18 = sat(m_res, 18); last_ch = m_ch;
      end
      m_cnt--;
    end
  end

  always @(negedge clk) begin
    bit     ev;
    longint e20, e18;
    int     ech;
    if (chk_en) begin
      ev  = (m_cnt == 1) && !flush && rst_n;
      e20 = ev ? sat(m_res, 20) : last20;
      e18 = ev ? sat(m_res, 18) : last18;
      ech = ev ? m_ch : last_ch;
      chk("in_ready", rdy, m_cnt == 0);
      chk("out_valid", ov, ev);
      chk("out_data", od, e20);
      chk("out_ch", och, ech);
      chk("sat_in_ready", rdy_s, m_cnt == 0);
      chk("sat_out_valid", ov_s, ev);
      chk("sat_out_data", od_s, e18);
      chk("sat_out_ch", och_s, ech);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && m_cnt != 0; i++) tick();
    if (m_cnt != 0) begin
      n_fail++;
      $display("FAIL idle_timeout: model still busy, count %0d", m_cnt);
    end
  endtask

  task automatic start(input bit ch, input int d, input bit we, input int a, input int cd);
    wait_idle();
    in_valid = 1'b1; in_ch = ch; in_data = d[7:0];
    coef_we = we; coef_addr = a[3:0]; coef_data = cd[7:0];
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic wait_out(output longint d, output longint ds, output int c, output int lat);
    d = -1; ds = -1; c = -1; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ov === 1'b1) begin
        d = od; ds = od_s; c = och; lat = i;
        break;
      end
    end
    tick();
  endtask

  task automatic run1(input bit ch, input int d, output longint r, output longint rs,
                      output int c, output int lat);
    start(ch, d, 1'b0, 0, 0);
    wait_out(r, rs, c, lat);
  endtask

  task automatic abort_check(input string name, input bit use_rst);
    longint r, rs;
    int     c, lat, pulses;
    start(1'b0, 100, 1'b0, 0, 0);
    repeat (4) tick();
    if (use_rst) rst_n = 1'b0; else flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk({name, "_ready_after"}, rdy, 1'b1);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (ov === 1'b1) pulses++;
      @(negedge clk);
    end
    chk({name, "_no_output"}, pulses, 0);
    tick();
    run1(1'b0, 100, r, rs, c, lat);
    chk({name, "_impulse_after"}, r, 200);
  endtask

  initial begin
    longint r, rs;
    int     c, lat, hk;
    int     acc_cyc[$];

    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", rdy, 1'b1);
    chk("reset_out_valid", ov, 1'b0);
    chk("reset_out_data", od, 0);
    chk("reset_out_ch", och, 1'b0);
    tick();

    // Impulse response on IR
    run1(1'b0, 100, r, rs, c, lat);
    chk("impulse_latency", lat, 12);
    chk("impulse_0", r, 200);
    chk("impulse_ch", c, 0);
    for (int k = 1; k < NT; k++) begin
      run1(1'b0, 0, r, rs, c, lat);
      hk = rc[(k < H) ? k : NT - 1 - k];
      chk($sformatf("impulse_%0d", k), r, 100 * hk);
    end

    // DC full scale on RED, then IR isolation
    for (int k = 0; k < NT; k++) run1(1'b1, 255, r, rs, c, lat);
    chk("dc_full_scale", r, 353430);
    chk("dc_ch", c, 1);
    chk("dc_saturated_18b", rs, 262143);
    run1(1'b0, 0, r, rs, c, lat);
    chk("ir_isolation", r, 0);
    chk("ir_isolation_ch", c, 0);

    // Coefficient write with the sample, then an ignored write during MAC
    wait_idle();
    flush = 1'b1; tick(); flush = 1'b0;
    start(1'b0, 1, 1'b1, 0, 255);
    wait_out(r, rs, c, lat);
    chk("coef_write_same_cycle", r, 255);
    start(1'b0, 0, 1'b0, 0, 0);
    coef_we = 1'b1; coef_addr = 4'd1; coef_data = 8'd7;
    tick();
    coef_we = 1'b0;
    wait_out(r, rs, c, lat);
    chk("coef_write_in_mac_ignored", r, 10);
    wait_idle();
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'd2;
    tick();
    coef_we = 1'b0;

    // Held in_valid: accepts spaced by H+2
    wait_idle();
    in_ch = 1'b0; in_data = 8'd1; in_valid = 1'b1;
    for (int i = 0; i < 60 && acc_cyc.size() < 3; i++) begin
      bit took;
      @(negedge clk);
      took = (rdy === 1'b1);
      if (took) acc_cyc.push_back(i);
      tick();
      if (took) in_data = in_data + 8'd1;
    end
    in_valid = 1'b0;
    chk("hold_accept_count", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("hold_gap_1", acc_cyc[1] - acc_cyc[0], 13);
      chk("hold_gap_2", acc_cyc[2] - acc_cyc[1], 13);
    end

    abort_check("abort_flush", 1'b0);
    abort_check("abort_reset", 1'b1);

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_ch     = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      coef_we   = ($urandom_range(0, 7) == 0);
      coef_addr = 4'($urandom);
      coef_data = 8'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      tick();
    end
    in_valid = 1'b0; coef_we = 1'b0; flush = 1'b0; rst_n = 1'b1;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
